// File: rtl/irq_arb_pkg.sv
// ============================================================================
// Module      : irq_arb_pkg
// Description : Shared definitions for the interrupt arbiter: register
//               addresses on the chained I/O bus (word address [15:2]), the
//               controller state encoding and the "nothing to claim" read
//               value.
// Macro       : IRQ_ARB_RR_EN (consumed by irq_arbiter, not used here)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_arb_pkg;

  // Width of a source id (four sources in this release)
  localparam int c_ID_W = 2;

  // Word addresses of the arbiter registers
  localparam logic [13:0] c_ADDR_ENABLE   = 14'h3E82;
  localparam logic [13:0] c_ADDR_PENDING  = 14'h3E83;
  localparam logic [13:0] c_ADDR_CLAIM    = 14'h3E84;
  localparam logic [13:0] c_ADDR_COMPLETE = 14'h3E85;

  // Returned by a CLAIM read that finds no request being asserted
  localparam logic [31:0] c_NO_CLAIM = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ============================================================================
// Module      : irq_prio_enc
// Description : Combinational winner selection over four pending bits. The
//               search starts at i_rr_ptr and wraps; a pointer held at zero
//               gives plain fixed priority (lowest index wins).
// Ports       : i_pending [3:0] - pending sources
//               i_rr_ptr  [1:0] - index searched first
//               o_valid         - at least one source pending
//               o_id      [1:0] - selected source
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_enc
  import irq_arb_pkg::*;
(
  input  logic [3:0]        i_pending,
  input  logic [c_ID_W-1:0] i_rr_ptr,
  output logic              o_valid,
  output logic [c_ID_W-1:0] o_id
);

  logic [c_ID_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest pending source
  // (relative to the pointer) is the last one written and therefore wins.
  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    w_idx   = '0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = i_rr_ptr + k[c_ID_W-1:0];
      if (i_pending[w_idx]) begin
        o_valid = 1'b1;
        o_id    = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_arbiter.sv
// ============================================================================
// Module      : irq_arbiter
// Description : Four-source external interrupt arbiter with enable/pending
//               registers, a read-to-claim / write-to-complete handshake and
//               a chained I/O read bus.
// Macro       : IRQ_ARB_RR_EN - when defined, winner selection is round-robin
//               (pointer advances past each claimed id); otherwise fixed
//               priority with the lowest index highest.
// Ports       : clk, rst_n (synchronous, active-low)
//               irq_src[3:0]           - one-cycle event pulses
//               csr_meie, csr_rmie     - external / global interrupt enables
//               g_interrupt            - request to CPU (ASSERT state only)
//               g_interrupt_1shot      - pulse in first ASSERT cycle
//               irq_id[1:0]            - claimed source id
//               dma_io_we/wadr/wdata   - register write port
//               dma_io_radr/radr_en    - register read request
//               dma_io_rdata_in/rdata  - chained read data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_arbiter
  import irq_arb_pkg::*;
#(
  parameter int NUM_SRC = 4
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               csr_meie,
  input  logic               csr_rmie,
  output logic               g_interrupt,
  output logic               g_interrupt_1shot,
  output logic [c_ID_W-1:0]  irq_id,
  input  logic               dma_io_we,
  input  logic [15:2]        dma_io_wadr,
  input  logic [31:0]        dma_io_wdata,
  input  logic [15:2]        dma_io_radr,
  input  logic               dma_io_radr_en,
  input  logic [31:0]        dma_io_rdata_in,
  output logic [31:0]        dma_io_rdata
);

  irq_state_e         r_state;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_pending;
  logic [c_ID_W-1:0]  r_irq_id;
  logic               r_g_int;
  logic               r_g_1shot;
  logic               r_rd_en;
  logic [15:2]        r_rd_adr;
  logic [31:0]        r_claim_rdata;

  logic               w_win_valid;
  logic [c_ID_W-1:0]  w_win_id;
  logic [c_ID_W-1:0]  w_rr_ptr;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_claim_mask;
  logic               w_claim_rd;
  logic               w_claim_ok;
  logic               w_complete_ok;
  logic               w_unused;

  // Upper write-data bits are not backed by any register
  assign w_unused = ^dma_io_wdata[31:NUM_SRC];

`ifdef IRQ_ARB_RR_EN
  logic [c_ID_W-1:0] r_rr_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_rr_ptr <= '0;
    else if (w_claim_ok)
      r_rr_ptr <= w_win_id + 2'd1;
  end

  assign w_rr_ptr = r_rr_ptr;
`else
  assign w_rr_ptr = '0;
`endif

  irq_prio_enc u_prio_enc (
    .i_pending (r_pending),
    .i_rr_ptr  (w_rr_ptr),
    .o_valid   (w_win_valid),
    .o_id      (w_win_id)
  );

  assign w_set         = irq_src & r_enable & {NUM_SRC{csr_meie}};
  assign w_claim_rd    = dma_io_radr_en && (dma_io_radr == c_ADDR_CLAIM);
  assign w_claim_ok    = w_claim_rd && (r_state == ST_ASSERT) && w_win_valid;
  assign w_claim_mask  = w_claim_ok ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << w_win_id) : '0;
  assign w_complete_ok = dma_io_we && (dma_io_wadr == c_ADDR_COMPLETE) &&
                         (r_state == ST_SERVICE) && (dma_io_wdata[1:0] == r_irq_id);

  // Enable and pending registers; a fresh event outranks a same-cycle claim.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_enable  <= '0;
      r_pending <= '0;
    end else begin
      if (dma_io_we && (dma_io_wadr == c_ADDR_ENABLE))
        r_enable <= dma_io_wdata[NUM_SRC-1:0];
      r_pending <= (r_pending & ~w_claim_mask) | w_set;
    end
  end

  // Controller: request line and one-shot are registered alongside the state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_g_int   <= 1'b0;
      r_g_1shot <= 1'b0;
      r_irq_id  <= '0;
    end else begin
      r_g_1shot <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if ((|r_pending) && csr_rmie) begin
            r_state   <= ST_ASSERT;
            r_g_int   <= 1'b1;
            r_g_1shot <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (w_claim_ok) begin
            r_state  <= ST_SERVICE;
            r_g_int  <= 1'b0;
            r_irq_id <= w_win_id;
          end else if (!csr_rmie || !(|r_pending)) begin
            r_state <= ST_IDLE;
            r_g_int <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (w_complete_ok)
            r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_g_int <= 1'b0;
        end
      endcase
    end
  end

  // Read request stage: the claim side effect happens at request time, so
  // its response word is captured here for return in the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_en       <= 1'b0;
      r_rd_adr      <= '0;
      r_claim_rdata <= '0;
    end else begin
      r_rd_en  <= dma_io_radr_en;
      r_rd_adr <= dma_io_radr;
      if (w_claim_rd)
        r_claim_rdata <= w_claim_ok ? {{(32-c_ID_W){1'b0}}, w_win_id} : c_NO_CLAIM;
    end
  end

  always_comb begin
    dma_io_rdata = dma_io_rdata_in;
    if (r_rd_en) begin
      case (r_rd_adr)
        c_ADDR_ENABLE:   dma_io_rdata = {{(32-NUM_SRC){1'b0}}, r_enable};
        c_ADDR_PENDING:  dma_io_rdata = {{(32-NUM_SRC){1'b0}}, r_pending};
        c_ADDR_CLAIM:    dma_io_rdata = r_claim_rdata;
        c_ADDR_COMPLETE: dma_io_rdata = '0;
        default:         dma_io_rdata = dma_io_rdata_in;
      endcase
    end
  end

  assign g_interrupt       = r_g_int;
  assign g_interrupt_1shot = r_g_1shot;
  assign irq_id            = r_irq_id;

endmodule

`default_nettype wire
